// File: rtl/vlb_share_pkg.sv
// Shared types and helpers for the vlb_share translation-request mux.
package vlb_share_pkg;

  localparam int ATTR_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [ATTR_W-1:0] attr;
  } vlb_meta_t;

  // Channel tag width; never narrower than one bit.
  function automatic int vlb_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vlb_share_rr_arb.sv
// N-way round-robin arbiter; priority starts just after the last granted channel.
module vlb_rr_arb #(
  parameter int N  = 2,
  parameter int CW = 1
) (
  input  logic          clk_sys_i,
  input  logic          rst_b_i,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [CW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [CW-1:0] ptr_q;
  logic [CW-1:0] ptr_d;
  logic [CW-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = CW'((int'(ptr_q) + i) % N);
      if (!any_o && req_i[cand]) begin
        any_o      = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o  = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && any_o) ptr_d = gnt_idx_o;
  end

  // Reset to the last channel so channel 0 is first in line.
  always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
    if (!rst_b_i) ptr_q <= CW'(N - 1);
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vlb_share.sv
// Shares one page-walker port among N clients: per-channel skid entry, round-robin
// grant, tag-routed responses/fills and a merged flush handshake.
//
// state    | meaning
// ST_IDLE  | normal operation, requests accepted and granted
// ST_FLUSH | skids emptied, waiting for every enabled channel to report flush done
module vlb_share
  import vlb_share_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 5,
  parameter int VW = 52,
  parameter int MW = 52,
  parameter int CW = vlb_cw(N)
) (
  input  logic                clk_sys_i,
  input  logic                rst_b_i,
  input  logic [N-1:0]        c_req_valid_i,
  input  logic [N*IW-1:0]     c_req_idx_i,
  input  logic [N*VW-1:0]     c_req_vpn_i,
  input  logic [N-1:0]        c_req_kill_i,
  output logic [N-1:0]        c_req_ready_o,
  output logic [N-1:0]        c_resp_valid_o,
  output logic [IW-1:0]       c_resp_idx_o,
  output logic                c_resp_vld_o,
  output logic                c_resp_err_o,
  output logic [MW-1:0]       c_resp_mpn_o,
  output logic [3:0]          c_resp_attr_o,
  output logic [N-1:0]        c_fill_valid_o,
  output logic [IW-1:0]       c_fill_idx_o,
  output logic                c_fill_vld_o,
  output logic                c_fill_err_o,
  output logic [MW-1:0]       c_fill_mpn_o,
  output logic [3:0]          c_fill_attr_o,
  output logic [N-1:0]        c_busy_o,
  input  logic [2*N-1:0]      c_kill_i,
  input  logic [N-1:0]        c_en_i,
  output logic                d_req_valid_o,
  input  logic                d_req_ready_i,
  output logic [CW+IW-1:0]    d_req_idx_o,
  output logic [VW-1:0]       d_req_vpn_o,
  output logic                d_req_kill_o,
  input  logic                d_resp_valid_i,
  input  logic [CW+IW-1:0]    d_resp_idx_i,
  input  logic                d_resp_vld_i,
  input  logic                d_resp_err_i,
  input  logic [MW-1:0]       d_resp_mpn_i,
  input  logic [3:0]          d_resp_attr_i,
  input  logic                d_fill_valid_i,
  input  logic [CW+IW-1:0]    d_fill_idx_i,
  input  logic                d_fill_vld_i,
  input  logic                d_fill_err_i,
  input  logic [MW-1:0]       d_fill_mpn_i,
  input  logic [3:0]          d_fill_attr_i,
  input  logic                d_busy_i,
  output logic [1:0]          d_kill_o
);

  flush_state_e         state_q, state_d;
  logic [N-1:0]         ack_q, ack_d;
  logic [N-1:0]         full_q, full_d;
  logic [N-1:0][IW-1:0] idx_q;
  logic [N-1:0][VW-1:0] vpn_q;
  logic [N-1:0]         kill_q;

  logic                 in_flush;
  logic                 flush_enter;
  logic [N-1:0]         kill_req;
  logic [N-1:0]         kill_done;
  logic                 any_kill;
  logic                 all_done;
  logic [N-1:0]         load;
  logic [N-1:0]         arb_req;
  logic [N-1:0]         gnt;
  logic [CW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic                 gnt_fire;
  logic [IW-1:0]        sel_idx;
  logic [VW-1:0]        sel_vpn;
  logic                 sel_kill;
  vlb_meta_t            resp_meta;
  vlb_meta_t            fill_meta;

  assign in_flush = (state_q == ST_FLUSH);

  always_comb begin
    kill_req  = '0;
    kill_done = '0;
    for (int c = 0; c < N; c++) begin
      kill_req[c]  = c_kill_i[2*c];
      kill_done[c] = c_kill_i[2*c+1];
    end
  end

  assign any_kill = |kill_req;
  assign all_done = &(kill_done | ack_q | ~c_en_i);
  assign d_kill_o = {in_flush & all_done, any_kill};

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    unique case (state_q)
      ST_IDLE: begin
        ack_d = '0;
        if (any_kill) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // A kill arriving with the done cycle still returns to IDLE first.
        if (all_done) begin
          state_d = ST_IDLE;
          ack_d   = '0;
        end else begin
          ack_d = ack_q | kill_done;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = '0;
      end
    endcase
  end

  assign flush_enter = (state_q == ST_IDLE) && (state_d == ST_FLUSH);

  assign c_req_ready_o = ~full_q & {N{~in_flush}};
  assign load          = c_req_valid_i & c_req_ready_o;
  assign arb_req       = full_q & {N{~in_flush}};

  vlb_rr_arb #(
    .N  (N),
    .CW (CW)
  ) u_arb (
    .clk_sys_i (clk_sys_i),
    .rst_b_i   (rst_b_i),
    .req_i     (arb_req),
    .adv_i     (gnt_fire),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign d_req_valid_o = gnt_any;
  assign gnt_fire      = gnt_any & d_req_ready_i;

  always_comb begin
    sel_idx  = '0;
    sel_vpn  = '0;
    sel_kill = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (gnt[c]) begin
        sel_idx  = sel_idx | idx_q[c];
        sel_vpn  = sel_vpn | vpn_q[c];
        sel_kill = sel_kill | kill_q[c];
      end
    end
  end

  assign d_req_idx_o  = {gnt_idx, sel_idx};
  assign d_req_vpn_o  = sel_vpn;
  assign d_req_kill_o = sel_kill;

  // Load only happens on an empty entry and grant only on a full one, so they never collide.
  always_comb begin
    full_d = full_q;
    for (int c = 0; c < N; c++) begin
      if (gnt_fire && gnt[c]) full_d[c] = 1'b0;
      else if (load[c])       full_d[c] = 1'b1;
    end
    if (flush_enter) full_d = '0;
  end

  always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
      full_q  <= '0;
      idx_q   <= '0;
      vpn_q   <= '0;
      kill_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      full_q  <= full_d;
      for (int c = 0; c < N; c++) begin
        if (load[c]) begin
          idx_q[c]  <= c_req_idx_i[c*IW +: IW];
          vpn_q[c]  <= c_req_vpn_i[c*VW +: VW];
          kill_q[c] <= c_req_kill_i[c];
        end
      end
    end
  end

  always_comb begin
    c_resp_valid_o = '0;
    c_fill_valid_o = '0;
    c_busy_o       = '0;
    for (int c = 0; c < N; c++) begin
      c_resp_valid_o[c] = d_resp_valid_i && (d_resp_idx_i[CW+IW-1:IW] == CW'(c));
      c_fill_valid_o[c] = d_fill_valid_i && (d_fill_idx_i[CW+IW-1:IW] == CW'(c));
      c_busy_o[c]       = d_busy_i && (d_fill_idx_i[CW+IW-1:IW] == CW'(c));
    end
  end

  assign resp_meta = '{vld: d_resp_vld_i, err: d_resp_err_i, attr: d_resp_attr_i};
  assign fill_meta = '{vld: d_fill_vld_i, err: d_fill_err_i, attr: d_fill_attr_i};

  assign c_resp_idx_o  = d_resp_idx_i[IW-1:0];
  assign c_resp_vld_o  = resp_meta.vld;
  assign c_resp_err_o  = resp_meta.err;
  assign c_resp_mpn_o  = d_resp_mpn_i;
  assign c_resp_attr_o = resp_meta.attr;

  assign c_fill_idx_o  = d_fill_idx_i[IW-1:0];
  assign c_fill_vld_o  = fill_meta.vld;
  assign c_fill_err_o  = fill_meta.err;
  assign c_fill_mpn_o  = d_fill_mpn_i;
  assign c_fill_attr_o = fill_meta.attr;

endmodule

// File: tb/tb_vlb_share.sv
// Directed bench for vlb_share with N=2: arbitration, routing, flush handshake, skid hold, reset.
module tb_vlb_share;

  localparam int N  = 2;
  localparam int IW = 5;
  localparam int VW = 52;
  localparam int MW = 52;
  localparam int CW = 1;

  logic                clk_sys = 1'b0;
  logic                rst_b;
  logic [N-1:0]        c_req_valid;
  logic [N*IW-1:0]     c_req_idx;
  logic [N*VW-1:0]     c_req_vpn;
  logic [N-1:0]        c_req_kill;
  logic [N-1:0]        c_req_ready;
  logic [N-1:0]        c_resp_valid;
  logic [IW-1:0]       c_resp_idx;
  logic                c_resp_vld;
  logic                c_resp_err;
  logic [MW-1:0]       c_resp_mpn;
  logic [3:0]          c_resp_attr;
  logic [N-1:0]        c_fill_valid;
  logic [IW-1:0]       c_fill_idx;
  logic                c_fill_vld;
  logic                c_fill_err;
  logic [MW-1:0]       c_fill_mpn;
  logic [3:0]          c_fill_attr;
  logic [N-1:0]        c_busy;
  logic [2*N-1:0]      c_kill;
  logic [N-1:0]        c_en;
  logic                d_req_valid;
  logic                d_req_ready;
  logic [CW+IW-1:0]    d_req_idx;
  logic [VW-1:0]       d_req_vpn;
  logic                d_req_kill;
  logic                d_resp_valid;
  logic [CW+IW-1:0]    d_resp_idx;
  logic                d_resp_vld;
  logic                d_resp_err;
  logic [MW-1:0]       d_resp_mpn;
  logic [3:0]          d_resp_attr;
  logic                d_fill_valid;
  logic [CW+IW-1:0]    d_fill_idx;
  logic                d_fill_vld;
  logic                d_fill_err;
  logic [MW-1:0]       d_fill_mpn;
  logic [3:0]          d_fill_attr;
  logic                d_busy;
  logic [1:0]          d_kill;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  vlb_share #(.N(N), .IW(IW), .VW(VW), .MW(MW), .CW(CW)) dut (
    .clk_sys_i      (clk_sys),
    .rst_b_i        (rst_b),
    .c_req_valid_i  (c_req_valid),
    .c_req_idx_i    (c_req_idx),
    .c_req_vpn_i    (c_req_vpn),
    .c_req_kill_i   (c_req_kill),
    .c_req_ready_o  (c_req_ready),
    .c_resp_valid_o (c_resp_valid),
    .c_resp_idx_o   (c_resp_idx),
    .c_resp_vld_o   (c_resp_vld),
    .c_resp_err_o   (c_resp_err),
    .c_resp_mpn_o   (c_resp_mpn),
    .c_resp_attr_o  (c_resp_attr),
    .c_fill_valid_o (c_fill_valid),
    .c_fill_idx_o   (c_fill_idx),
    .c_fill_vld_o   (c_fill_vld),
    .c_fill_err_o   (c_fill_err),
    .c_fill_mpn_o   (c_fill_mpn),
    .c_fill_attr_o  (c_fill_attr),
    .c_busy_o       (c_busy),
    .c_kill_i       (c_kill),
    .c_en_i         (c_en),
    .d_req_valid_o  (d_req_valid),
    .d_req_ready_i  (d_req_ready),
    .d_req_idx_o    (d_req_idx),
    .d_req_vpn_o    (d_req_vpn),
    .d_req_kill_o   (d_req_kill),
    .d_resp_valid_i (d_resp_valid),
    .d_resp_idx_i   (d_resp_idx),
    .d_resp_vld_i   (d_resp_vld),
    .d_resp_err_i   (d_resp_err),
    .d_resp_mpn_i   (d_resp_mpn),
    .d_resp_attr_i  (d_resp_attr),
    .d_fill_valid_i (d_fill_valid),
    .d_fill_idx_i   (d_fill_idx),
    .d_fill_vld_i   (d_fill_vld),
    .d_fill_err_i   (d_fill_err),
    .d_fill_mpn_i   (d_fill_mpn),
    .d_fill_attr_i  (d_fill_attr),
    .d_busy_i       (d_busy),
    .d_kill_o       (d_kill)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    rst_b = 1'b0;
    c_req_valid = '0; c_req_idx = '0; c_req_vpn = '0; c_req_kill = '0;
    c_kill = '0; c_en = 2'b11; d_req_ready = 1'b0;
    d_resp_valid = 1'b0; d_resp_idx = '0; d_resp_vld = 1'b0; d_resp_err = 1'b0;
    d_resp_mpn = '0; d_resp_attr = '0;
    d_fill_valid = 1'b0; d_fill_idx = '0; d_fill_vld = 1'b0; d_fill_err = 1'b0;
    d_fill_mpn = '0; d_fill_attr = '0; d_busy = 1'b0;
    #3;
    chk("rst_d_req_valid", d_req_valid, 0);
    chk("rst_d_kill", d_kill, 0);
    tick(); tick();
    rst_b = 1'b1;
    #1;
    chk("rel_ready", c_req_ready, 2'b11);
    chk("rel_d_req_valid", d_req_valid, 0);

    // Both channels request together; ch0 first, then ch1.
    tick();
    c_req_valid = 2'b11;
    c_req_idx   = {5'd7, 5'd3};
    c_req_vpn   = {52'h222, 52'h111};
    c_req_kill  = 2'b10;
    d_req_ready = 1'b1;
    #1;
    chk("arb_pre_valid", d_req_valid, 0);
    tick();
    c_req_valid = '0;
    #1;
    chk("arb0_valid", d_req_valid, 1);
    chk("arb0_idx", d_req_idx, 6'h03);
    chk("arb0_vpn", d_req_vpn, 52'h111);
    chk("arb0_kill", d_req_kill, 0);
    chk("arb0_ready", c_req_ready, 2'b00);
    tick();
    #1;
    chk("arb1_valid", d_req_valid, 1);
    chk("arb1_idx", d_req_idx, 6'h27);
    chk("arb1_vpn", d_req_vpn, 52'h222);
    chk("arb1_kill", d_req_kill, 1);
    chk("arb1_ready", c_req_ready, 2'b01);
    tick();
    #1;
    chk("arb_done_valid", d_req_valid, 0);
    chk("arb_done_ready", c_req_ready, 2'b11);

    // Fill / busy / response routing.
    d_fill_valid = 1'b1; d_fill_idx = 6'h25; d_fill_mpn = 52'hABCDE; d_fill_attr = 4'h9;
    d_fill_vld = 1'b1;
    #1;
    chk("fill_valid", c_fill_valid, 2'b10);
    chk("fill_idx", c_fill_idx, 5);
    chk("fill_mpn", c_fill_mpn, 52'hABCDE);
    chk("fill_attr", c_fill_attr, 4'h9);
    chk("fill_busy_idle", c_busy, 2'b00);
    d_fill_valid = 1'b0; d_fill_idx = 6'h05; d_busy = 1'b1;
    #1;
    chk("busy_route", c_busy, 2'b01);
    chk("busy_fill_valid", c_fill_valid, 2'b00);
    d_busy = 1'b0;
    d_resp_valid = 1'b1; d_resp_idx = 6'h27; d_resp_err = 1'b1; d_resp_mpn = 52'h5A5A;
    #1;
    chk("resp_valid", c_resp_valid, 2'b10);
    chk("resp_idx", c_resp_idx, 7);
    chk("resp_err", c_resp_err, 1);
    chk("resp_mpn", c_resp_mpn, 52'h5A5A);
    d_resp_idx = 6'h01;
    #1;
    chk("resp_valid_ch0", c_resp_valid, 2'b01);
    d_resp_valid = 1'b0;

    // Flush: ch0 requests at t, ch0 done at t+2, ch1 done at t+4.
    tick();
    c_kill = 4'b0001;
    #1;
    chk("fl_t0_dkill", d_kill, 2'b01);
    tick();
    c_kill = 4'b0000;
    #1;
    chk("fl_t1_dkill", d_kill, 2'b00);
    chk("fl_t1_ready", c_req_ready, 2'b00);
    tick();
    c_kill = 4'b0010;
    #1;
    chk("fl_t2_dkill", d_kill, 2'b00);
    tick();
    c_kill = 4'b0000;
    #1;
    chk("fl_t3_dkill", d_kill, 2'b00);
    tick();
    c_kill = 4'b1000;
    #1;
    chk("fl_t4_dkill", d_kill, 2'b10);
    tick();
    c_kill = 4'b0000;
    #1;
    chk("fl_t5_dkill", d_kill, 2'b00);
    chk("fl_t5_ready", c_req_ready, 2'b11);

    // Only ch0 enabled: its ack alone completes the flush.
    c_en = 2'b01;
    c_kill = 4'b0001;
    tick();
    c_kill = 4'b0000;
    #1;
    chk("en01_wait", d_kill, 2'b00);
    c_kill = 4'b0010;
    #1;
    chk("en01_done", d_kill, 2'b10);
    tick();
    c_kill = 4'b0000;
    #1;
    chk("en01_idle_ready", c_req_ready, 2'b11);

    // No channel enabled: done asserts on the first FLUSH cycle.
    c_en = 2'b00;
    c_kill = 4'b0001;
    tick();
    c_kill = 4'b0000;
    #1;
    chk("en00_done", d_kill, 2'b10);
    tick();
    #1;
    chk("en00_idle_ready", c_req_ready, 2'b11);
    c_en = 2'b11;

    // Skid holds while the walker stalls; a second valid is ignored.
    d_req_ready = 1'b0;
    c_req_valid = 2'b01;
    c_req_idx   = {5'd0, 5'd9};
    c_req_vpn   = {52'h0, 52'hABC};
    c_req_kill  = 2'b00;
    tick();
    c_req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        c_req_valid = 2'b01;
        c_req_idx   = {5'd0, 5'd12};
        c_req_vpn   = {52'h0, 52'hDEF};
      end else begin
        c_req_valid = 2'b00;
      end
      #1;
      chk("hold_ready", c_req_ready, 2'b10);
      chk("hold_valid", d_req_valid, 1);
      chk("hold_vpn", d_req_vpn, 52'hABC);
      chk("hold_idx", d_req_idx, 6'h09);
      tick();
    end
    c_req_valid = 2'b00;
    d_req_ready = 1'b1;
    #1;
    chk("hold_grant_vpn", d_req_vpn, 52'hABC);
    tick();
    #1;
    chk("hold_after_valid", d_req_valid, 0);

    // Reset mid-handshake drops held requests at once.
    d_req_ready = 1'b0;
    c_req_valid = 2'b11;
    tick();
    c_req_valid = 2'b00;
    #1;
    chk("mid_valid_pre", d_req_valid, 1);
    rst_b = 1'b0;
    #1;
    chk("mid_valid_async", d_req_valid, 0);
    tick(); tick();
    rst_b = 1'b1;
    d_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_idle", d_req_valid, 0);
      tick();
    end
    c_req_valid = 2'b10;
    c_req_idx   = {5'd4, 5'd0};
    c_req_vpn   = {52'h777, 52'h0};
    tick();
    c_req_valid = 2'b00;
    #1;
    chk("post_rst_new_valid", d_req_valid, 1);
    chk("post_rst_new_idx", d_req_idx, 6'h24);
    chk("post_rst_new_vpn", d_req_vpn, 52'h777);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vlb_share.md
VLB_SHARE -- requirements
Module: vlb_share

Interface
REQ-001 Parameters SHALL be: N, default 2, client channel count (2..8); IW, default 5, client idx width; VW, default 52, vpn width; MW, default 52, mpn width; CW, default $clog2(N), channel tag width.
REQ-002 Ports SHALL be, clock and reset first:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- c_req_valid  in  N  client translation request
- c_req_idx  in  N x IW  client tag
- c_req_vpn  in  N x VW  client vpn
- c_req_kill  in  N  client request kill bit
- c_req_ready  out  N  skid slot free
- c_resp_valid / c_fill_valid / c_busy  out  N each  routed response / fill / busy
- c_resp_* / c_fill_*  out  idx IW, vld 1, err 1, mpn MW, attr 4  broadcast payload
- c_kill  in  N x 2  [0] flush request, [1] flush done
- c_en  in  N  channel participates in flush handshake
- d_req_valid  out  1  request to walker
- d_req_ready  in  1  walker accept
- d_req_idx  out  CW+IW  {channel, client idx}
- d_req_vpn  out  VW  selected vpn
- d_req_kill  out  1  selected kill bit
- d_resp_* / d_fill_*  in  valid, idx CW+IW, vld, err, mpn, attr  walker response / fill
- d_busy  in  1  walker fill busy
- d_kill  out  2  merged kill

Function
REQ-003 Each channel SHALL own a one-entry skid register; c_req_ready[c] = ~full[c]; c_req_valid while ~full loads the entry the same edge.
REQ-004 c_req_valid while full SHALL be ignored; the entry is unchanged.
REQ-005 Arbitration SHALL be round-robin over full entries, starting after the last granted channel; the pointer SHALL reset to N-1 so channel 0 wins first.
REQ-006 d_req_valid SHALL be registered-output-free (driven from skid state); grant completes on d_req_valid & d_req_ready, clearing that entry.
REQ-007 Load and grant of the same channel in one cycle SHALL be legal only when the channel was full at cycle start: the entry empties, and the new request is not accepted because ready was 0.
REQ-008 Minimum latency from c_req_valid to d_req_valid SHALL be 1 cycle.
REQ-009 d_req_idx SHALL be {c, c_req_idx}; CW upper bits carry the channel.
REQ-010 c_resp_valid[c] = d_resp_valid & (d_resp_idx[top CW] == c); the payload is the low IW idx bits, and the rest is broadcast combinationally.
REQ-011 c_fill_valid[c] and c_busy[c] SHALL decode identically from d_fill_idx; d_busy routes only to the decoded channel.
REQ-012 Tag values >= N SHALL route to no channel.
REQ-013 Flush FSM with states IDLE and FLUSH:
- IDLE->FLUSH when any c_kill[c][0]
- FLUSH->IDLE the cycle d_kill[1] is asserted
REQ-014 d_kill[0] = OR over c of c_kill[c][0], combinational in any state.
REQ-015 ack_q[c] SHALL set in FLUSH on c_kill[c][1] and clear on the FLUSH->IDLE transition.
REQ-016 d_kill[1] = FLUSH & AND over c of (c_kill[c][1] | ack_q[c] | ~c_en[c]).
REQ-017 If every c_en is 0, d_kill[1] SHALL assert the first FLUSH cycle.
REQ-018 A new c_kill[0] in the same cycle as d_kill[1] SHALL move the FSM to IDLE; it re-enters FLUSH the next cycle if the kill persists.
REQ-019 On entering FLUSH, all skid entries SHALL be cleared and no grant issued while in FLUSH; c_req_ready = 0 in FLUSH.

Reset
REQ-020 On reset low, immediately and asynchronously:
- skid entries empty
- rr pointer N-1
- FSM IDLE
- ack_q 0
- d_req_valid 0
- c_req_ready all 1 after release
REQ-021 Reset asserted mid-handshake SHALL discard held requests without any d_req_valid pulse.

Structure
REQ-022 The payload struct, CW computation and FSM enum SHALL live in the shared vlb package.
REQ-023 A single sub-module, vlb_rr_arb (N-way round-robin arbiter), SHALL be instantiated; all else is inline.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- N=2, both channels request idx 3 and idx 7 same cycle, d_req_ready=1 -> d_req_idx 0x03 then 0x27 on consecutive cycles.
- d_fill_valid with idx 0x25 -> c_fill_valid = 2'b10, c_fill_idx = 5; with idx 0x05 d_busy=1 -> c_busy = 2'b01.
- ch0 kill[0], ch0 kill[1] at t+2, ch1 kill[1] at t+4 -> d_kill[1] at t+4 only, then IDLE.
- c_en = 2'b01, ch0 flushes and acks -> d_kill[1] without ch1 ack.
- Skid full with d_req_ready=0 for 5 cycles -> c_req_ready 0, vpn held; a second valid is ignored.
- Reset pulled low while d_req_valid=1 -> d_req_valid drops immediately and nothing is granted after release until new requests arrive.
